parking_gate_ctrl: RTL
======================

Name: parking_gate_ctrl

Overview:
- Upstream stage of the parking occupancy counter. Converts raw entry/exit lane sensors and badge readers into clean single-cycle car_entered / car_exited events.
- Entry barrier admits a car only when the occupancy block reports vacancy. Exit barrier always opens.
- The outputs drive the occupancy counter's car_entered, is_uni_car_enterd, car_exited and is_uni_car_exited inputs directly.

Parameters:
DEBOUNCE, 4, consecutive stable cycles required before a sensor change is accepted
CLOSE_CYCLES, 8, cycles a barrier stays down after closing, sensors ignored
OPEN_TIMEOUT, 1000, cycles in OPEN after which the lane alarm asserts
CNT_W, 16, width of saturating statistics counters

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
entry_sensor  in  1  raw entry loop detector, 1 = vehicle present
entry_is_uni  in  1  entry badge reader, 1 = university car
exit_sensor  in  1  raw exit loop detector
exit_is_uni  in  1  exit badge reader
uni_is_vacated_space  in  1  from occupancy block: university space free
is_vacated_space  in  1  from occupancy block: free space available
entry_gate_open  out  1  entry barrier up
exit_gate_open  out  1  exit barrier up
car_entered  out  1  one-cycle pulse, car passed entry barrier
is_uni_car_enterd  out  1  class of the admitted car, held stable
car_exited  out  1  one-cycle pulse, car passed exit barrier
is_uni_car_exited  out  1  class of the exiting car, held stable
entry_reject  out  1  one-cycle pulse, car refused for lack of space
entry_alarm  out  1  entry barrier open longer than OPEN_TIMEOUT
exit_alarm  out  1  exit barrier open longer than OPEN_TIMEOUT
reject_count  out  CNT_W  saturating count of rejections

Behaviour:
- Reset (async assert, sync release): all outputs 0, both FSMs IDLE, debounce filters 0, counters 0. Reset mid-operation closes the barrier immediately and emits no pulse.
- Debounce, per sensor: the filtered value flips only after the raw value differs from it for DEBOUNCE consecutive cycles. Any glitch restarts the count.
- Entry FSM states: IDLE, DECIDE, OPEN, REJ_WAIT, CLOSE.
  - IDLE -> DECIDE on a filtered rising edge. Latch entry_is_uni in that cycle.
  - DECIDE lasts 1 cycle and samples the vacancy inputs.
    - Admit if latched uni=1 and (uni_is_vacated_space or is_vacated_space). This matches the occupancy block's overflow into free space.
    - Admit if latched uni=0 and is_vacated_space.
    - If admitted -> OPEN. Otherwise -> REJ_WAIT, pulse entry_reject, and increment reject_count (saturates at all-ones).
  - OPEN: entry_gate_open=1. A cycle counter starts at 0 on entry and counts every cycle. entry_alarm=1 once the counter reaches OPEN_TIMEOUT and stays 1 until OPEN is left.
    - On the filtered falling edge, pulse car_entered for exactly 1 cycle, then go to CLOSE.
    - is_uni_car_enterd updates to the latched class one cycle before the pulse and holds until the next admitted car.
  - REJ_WAIT: wait for the filtered falling edge -> IDLE. The barrier stays down.
  - CLOSE: entry_gate_open=0 for CLOSE_CYCLES cycles, sensor ignored -> IDLE. A car still present on return to IDLE needs a fresh filtered rising edge.
- Exit FSM: same structure with states IDLE, OPEN, CLOSE. There is no admission check: IDLE -> OPEN on the filtered rising edge, latching exit_is_uni. The output rules for car_exited, is_uni_car_exited and exit_alarm mirror the entry lane.
- Latency, entry admit: raw sensor first sampled high at edge k and stable -> filtered high at k+DEBOUNCE -> DECIDE at k+DEBOUNCE+1 -> entry_gate_open high at k+DEBOUNCE+2. Exit lane: gate open at k+DEBOUNCE+1.
- Latency, pulses: the car_entered / car_exited pulse is asserted in the first cycle after the filtered falling edge is detected.
- Lanes are fully independent. car_entered and car_exited in the same cycle is legal and passed through unchanged.
- Vacancy inputs are sampled only in DECIDE. Vacancy lost while OPEN does not close the barrier; the occupancy block handles overflow.
- Badge inputs are sampled only on the IDLE->DECIDE / IDLE->OPEN transition. Later changes are ignored.
- All outputs are registered. No combinational path from inputs to outputs.

Test Plan:
- DEBOUNCE=4. entry_sensor high 10 cycles then low, entry_is_uni=1, uni_is_vacated_space=1 -> gate opens 6 cycles after first high sample. One car_entered pulse is emitted with is_uni_car_enterd=1. Gate is down for 8 cycles, then IDLE.
- entry_is_uni=0, is_vacated_space=0, uni_is_vacated_space=1 -> entry_reject pulse, reject_count 0->1, gate never opens, no car_entered.
- entry_is_uni=1, uni_is_vacated_space=0, is_vacated_space=1 -> admitted, car_entered pulse with is_uni_car_enterd=1.
- Sensor glitch of 3 cycles (< DEBOUNCE) on both lanes -> no state change, no pulses.
- Simultaneous entry and exit cars with identical timing -> car_entered and car_exited pulse in the same cycle. Exit lane leads entry by 1 cycle when entry is admitted.
- OPEN_TIMEOUT=20, entry sensor held 40 cycles -> entry_alarm rises 20 cycles after gate open and clears when the car leaves. rst_n asserted while OPEN -> gate closes immediately, no pulse, counters 0.

Source files
------------

// File: rtl/parking_gate_ctrl.sv
// -----------------------------------------------------------------------------
// parking_gate_ctrl
//
// Front end of the parking occupancy counter. It cleans the raw entry/exit
// loop detectors, runs one barrier FSM per lane and produces single-cycle
// car_entered / car_exited events with the class of the car held alongside.
// The entry barrier admits a car only when the occupancy block reports room;
// the exit barrier always opens.
//
// Ports
//   clk                   system clock, everything on the rising edge
//   rst_n                 asynchronous active-low reset
//   entry_sensor          raw entry loop detector (1 = vehicle present)
//   entry_is_uni          entry badge reader (1 = university car)
//   exit_sensor           raw exit loop detector
//   exit_is_uni           exit badge reader
//   uni_is_vacated_space  occupancy block: university space free
//   is_vacated_space      occupancy block: general free space available
//   entry_gate_open       entry barrier up
//   exit_gate_open        exit barrier up
//   car_entered           one-cycle pulse, car passed the entry barrier
//   is_uni_car_enterd     class of the last admitted car, held
//   car_exited            one-cycle pulse, car passed the exit barrier
//   is_uni_car_exited     class of the last exiting car, held
//   entry_reject          one-cycle pulse, car refused for lack of space
//   entry_alarm           entry barrier open for OPEN_TIMEOUT cycles or more
//   exit_alarm            exit barrier open for OPEN_TIMEOUT cycles or more
//   reject_count          saturating count of refused cars
//   entry_state           debug: entry FSM state
//                         (0 IDLE, 1 DECIDE, 2 OPEN, 3 REJ_WAIT, 4 CLOSE)
//   exit_state            debug: exit FSM state (0 IDLE, 1 OPEN, 2 CLOSE)
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// pgc_debounce
//
// Sensor filter. The raw input is first registered (this also acts as the
// synchroniser for the asynchronous loop detector), then the filtered value
// flips only after the registered sample has differed from it for DEBOUNCE
// consecutive cycles. Any sample equal to the filtered value restarts the run.
//
// Ports
//   clk, rst_n  clock and asynchronous active-low reset
//   raw         raw sensor input
//   filt        debounced sensor value
//   flip        high in the cycle whose clock edge will toggle filt
// -----------------------------------------------------------------------------
module pgc_debounce #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic filt,
  output logic flip
);

  localparam int CW = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  logic          raw_q;
  logic [CW-1:0] cnt;

  // The DEBOUNCE-th differing sample flips the output at this edge.
  assign flip = (raw_q != filt) && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_q <= 1'b0;
      filt  <= 1'b0;
      cnt   <= '0;
    end else begin
      raw_q <= raw;
      if (raw_q == filt) begin
        cnt <= '0;
      end else if (flip) begin
        filt <= raw_q;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

module parking_gate_ctrl #(
  parameter int DEBOUNCE     = 4,
  parameter int CLOSE_CYCLES = 8,
  parameter int OPEN_TIMEOUT = 1000,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             entry_sensor,
  input  logic             entry_is_uni,
  input  logic             exit_sensor,
  input  logic             exit_is_uni,
  input  logic             uni_is_vacated_space,
  input  logic             is_vacated_space,
  output logic             entry_gate_open,
  output logic             exit_gate_open,
  output logic             car_entered,
  output logic             is_uni_car_enterd,
  output logic             car_exited,
  output logic             is_uni_car_exited,
  output logic             entry_reject,
  output logic             entry_alarm,
  output logic             exit_alarm,
  output logic [CNT_W-1:0] reject_count,
  output logic [2:0]       entry_state,
  output logic [1:0]       exit_state
);

  // One timer per lane serves both the OPEN watchdog and the CLOSE hold time,
  // so it is sized for the larger of the two.
  localparam int TMAX = (OPEN_TIMEOUT > CLOSE_CYCLES) ? OPEN_TIMEOUT : CLOSE_CYCLES;
  localparam int TW   = (TMAX < 1) ? 1 : $clog2(TMAX + 1);
  localparam logic [TW-1:0] T_OPEN       = TW'(OPEN_TIMEOUT);
  localparam logic [TW-1:0] T_CLOSE_LAST = TW'(CLOSE_CYCLES - 1);

  typedef enum logic [2:0] {
    E_IDLE     = 3'd0,
    E_DECIDE   = 3'd1,
    E_OPEN     = 3'd2,
    E_REJ_WAIT = 3'd3,
    E_CLOSE    = 3'd4
  } entry_state_t;

  typedef enum logic [1:0] {
    X_IDLE  = 2'd0,
    X_OPEN  = 2'd1,
    X_CLOSE = 2'd2
  } exit_state_t;

  // ---------------------------------------------------------------------------
  // Reset: asserts asynchronously, releases on a clock edge through a
  // two-stage synchroniser so every flop leaves reset in the same cycle.
  // ---------------------------------------------------------------------------
  logic [1:0] rst_pipe;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_pipe <= 2'b00;
    else        rst_pipe <= {rst_pipe[0], 1'b1};
  end

  assign rst_int_n = rst_pipe[1];

  // ---------------------------------------------------------------------------
  // Sensor filters and edge detection
  // ---------------------------------------------------------------------------
  logic en_filt, en_flip, en_filt_d, en_rise;
  logic ex_filt, ex_flip, ex_filt_d, ex_rise;

  pgc_debounce #(.DEBOUNCE(DEBOUNCE)) u_entry_db (
    .clk   (clk),
    .rst_n (rst_int_n),
    .raw   (entry_sensor),
    .filt  (en_filt),
    .flip  (en_flip)
  );

  pgc_debounce #(.DEBOUNCE(DEBOUNCE)) u_exit_db (
    .clk   (clk),
    .rst_n (rst_int_n),
    .raw   (exit_sensor),
    .filt  (ex_filt),
    .flip  (ex_flip)
  );

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      en_filt_d <= 1'b0;
      ex_filt_d <= 1'b0;
    end else begin
      en_filt_d <= en_filt;
      ex_filt_d <= ex_filt;
    end
  end

  // A true edge is needed to start a lane, so a car still sitting on the loop
  // after CLOSE does not retrigger the barrier.
  assign en_rise = en_filt & ~en_filt_d;
  assign ex_rise = ex_filt & ~ex_filt_d;

  // ---------------------------------------------------------------------------
  // Entry lane FSM
  // ---------------------------------------------------------------------------
  entry_state_t  e_state, e_next;
  logic [TW-1:0] e_tmr, e_tmr_next;
  logic          e_uni_lat;
  logic          e_admit;

  // University cars may overflow into general free space.
  assign e_admit = e_uni_lat ? (uni_is_vacated_space | is_vacated_space)
                             : is_vacated_space;

  always_comb begin
    e_next     = e_state;
    e_tmr_next = e_tmr;
    case (e_state)
      E_IDLE: begin
        if (en_rise) e_next = E_DECIDE;
      end
      E_DECIDE: begin
        e_tmr_next = '0;
        if (e_admit) e_next = E_OPEN;
        else         e_next = E_REJ_WAIT;
      end
      E_OPEN: begin
        // Leaving on the filtered level rather than an edge cannot miss a
        // departure that completed while the lane was deciding.
        if (!en_filt) begin
          e_next     = E_CLOSE;
          e_tmr_next = '0;
        end else if (e_tmr < T_OPEN) begin
          e_tmr_next = e_tmr + 1'b1;
        end
      end
      E_REJ_WAIT: begin
        if (!en_filt) e_next = E_IDLE;
      end
      E_CLOSE: begin
        if (e_tmr >= T_CLOSE_LAST) begin
          e_next     = E_IDLE;
          e_tmr_next = '0;
        end else begin
          e_tmr_next = e_tmr + 1'b1;
        end
      end
      default: begin
        e_next     = E_IDLE;
        e_tmr_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      e_state           <= E_IDLE;
      e_tmr             <= '0;
      e_uni_lat         <= 1'b0;
      entry_gate_open   <= 1'b0;
      entry_alarm       <= 1'b0;
      car_entered       <= 1'b0;
      is_uni_car_enterd <= 1'b0;
      entry_reject      <= 1'b0;
      reject_count      <= '0;
    end else begin
      e_state         <= e_next;
      e_tmr           <= e_tmr_next;
      entry_gate_open <= (e_next == E_OPEN);
      entry_alarm     <= (e_next == E_OPEN) && (e_tmr_next >= T_OPEN);
      car_entered     <= (e_state == E_OPEN) && !en_filt;
      entry_reject    <= (e_state == E_DECIDE) && !e_admit;

      // Badge is captured only when the lane wakes up.
      if ((e_state == E_IDLE) && en_rise) e_uni_lat <= entry_is_uni;

      // The class is published on the edge where the filter drops (one cycle
      // ahead of the pulse) and re-written with the pulse for robustness.
      if ((e_state == E_OPEN) && (en_flip || !en_filt))
        is_uni_car_enterd <= e_uni_lat;

      if ((e_state == E_DECIDE) && !e_admit && (reject_count != {CNT_W{1'b1}}))
        reject_count <= reject_count + 1'b1;
    end
  end

  assign entry_state = e_state;

  // ---------------------------------------------------------------------------
  // Exit lane FSM: no admission decision, otherwise mirrors the entry lane.
  // ---------------------------------------------------------------------------
  exit_state_t   x_state, x_next;
  logic [TW-1:0] x_tmr, x_tmr_next;
  logic          x_uni_lat;

  always_comb begin
    x_next     = x_state;
    x_tmr_next = x_tmr;
    case (x_state)
      X_IDLE: begin
        if (ex_rise) begin
          x_next     = X_OPEN;
          x_tmr_next = '0;
        end
      end
      X_OPEN: begin
        if (!ex_filt) begin
          x_next     = X_CLOSE;
          x_tmr_next = '0;
        end else if (x_tmr < T_OPEN) begin
          x_tmr_next = x_tmr + 1'b1;
        end
      end
      X_CLOSE: begin
        if (x_tmr >= T_CLOSE_LAST) begin
          x_next     = X_IDLE;
          x_tmr_next = '0;
        end else begin
          x_tmr_next = x_tmr + 1'b1;
        end
      end
      default: begin
        x_next     = X_IDLE;
        x_tmr_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      x_state           <= X_IDLE;
      x_tmr             <= '0;
      x_uni_lat         <= 1'b0;
      exit_gate_open    <= 1'b0;
      exit_alarm        <= 1'b0;
      car_exited        <= 1'b0;
      is_uni_car_exited <= 1'b0;
    end else begin
      x_state        <= x_next;
      x_tmr          <= x_tmr_next;
      exit_gate_open <= (x_next == X_OPEN);
      exit_alarm     <= (x_next == X_OPEN) && (x_tmr_next >= T_OPEN);
      car_exited     <= (x_state == X_OPEN) && !ex_filt;

      if ((x_state == X_IDLE) && ex_rise) x_uni_lat <= exit_is_uni;

      if ((x_state == X_OPEN) && (ex_flip || !ex_filt))
        is_uni_car_exited <= x_uni_lat;
    end
  end

  assign exit_state = x_state;

endmodule
